// File: rtl/reg_wb_pkg.sv
// Shared types for the register write-back path.
// Holds the register address/data widths and the buffered write record.
package reg_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundles the pipeline, long-unit, decode-read and register-file signals
// that meet at the write-back arbiter.
interface reg_write_arbiter_if;
  import reg_wb_pkg::*;

  logic                  pipe_wr;
  logic [REG_ADDR_W-1:0] pipe_addr;
  logic [REG_DATA_W-1:0] pipe_data;
  logic                  lu_issue;
  logic [REG_ADDR_W-1:0] lu_issue_addr;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_addr;
  logic [REG_DATA_W-1:0] lu_data;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] rd_addr1;
  logic [REG_ADDR_W-1:0] rd_addr2;
  logic                  rf_wr;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [REG_DATA_W-1:0] rf_data;
  logic                  stall;
  logic [31:0]           pending;

  modport master (
    output pipe_wr, pipe_addr, pipe_data, lu_issue, lu_issue_addr,
           lu_valid, lu_addr, lu_data, rd_addr1, rd_addr2,
    input  lu_ready, rf_wr, rf_addr, rf_data, stall, pending
  );

  modport slave (
    input  pipe_wr, pipe_addr, pipe_data, lu_issue, lu_issue_addr,
           lu_valid, lu_addr, lu_data, rd_addr1, rd_addr2,
    output lu_ready, rf_wr, rf_addr, rf_data, stall, pending
  );

endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of pending long-unit register writes.
// Push is ignored when full and pop when empty, so callers cannot corrupt the count.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wr_entry_t        mem_q [DEPTH];
  wr_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the single register-file write port between the main pipeline and
// buffered long-unit results, tracking in-flight destinations to raise stalls.
module reg_write_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  reg_write_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  wr_entry_t         head;
  wr_entry_t         push_entry;
  logic              full, empty;
  logic              push, pop;
  logic              force_head, waw, pipe_sel, lu_ready;
  logic              active_q, active_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       pending_q, pending_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Ready only comes up on the first clock after reset, keeping lu_ready low throughout reset.
  assign lu_ready   = active_q && !full;
  assign push       = bus.lu_valid && lu_ready && (bus.lu_addr != REG_ZERO);
  assign push_entry = '{addr: bus.lu_addr, data: bus.lu_data};
  assign bus.lu_ready = lu_ready;
  assign bus.pending  = pending_q;

  always_comb begin
    force_head  = !empty && (wait_q >= WAIT_W'(STARVE_LIMIT));
    waw         = bus.pipe_wr && (bus.pipe_addr != REG_ZERO) && pending_q[bus.pipe_addr];
    pipe_sel    = !force_head && bus.pipe_wr && (bus.pipe_addr != REG_ZERO) && !waw;
    pop         = !pipe_sel && !empty;
    bus.rf_wr   = 1'b0;
    bus.rf_addr = REG_ZERO;
    bus.rf_data = '0;
    if (reset) begin
      if (pipe_sel) begin
        bus.rf_wr   = 1'b1;
        bus.rf_addr = bus.pipe_addr;
        bus.rf_data = bus.pipe_data;
      end else if (!empty) begin
        bus.rf_wr   = 1'b1;
        bus.rf_addr = head.addr;
        bus.rf_data = head.data;
      end
    end
    bus.stall = force_head || waw || pending_q[bus.rd_addr1] || pending_q[bus.rd_addr2];
  end

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    active_d  = 1'b1;
    pending_d = pending_q;
    if (pop) begin
      pending_d[head.addr] = 1'b0;
    end
    if (bus.lu_issue && (bus.lu_issue_addr != REG_ZERO)) begin
      pending_d[bus.lu_issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
    wait_d = wait_q;
    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(STARVE_LIMIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q  <= 1'b0;
      wait_q    <= '0;
      pending_q <= '0;
    end else begin
      active_q  <= active_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: every register-file write is
// matched in order against a queue of expected writes filled as stimulus is driven.
module tb_reg_write_arbiter;
  import reg_wb_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  wr_entry_t exp_q [$];

  int exp_addr_37 [17] = '{3, 3, 3, 3, 3, 4, 3, 3, 3, 3, 5, 3, 3, 3, 3, 6, 3};
  bit exp_rdy_37  [17] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  reg_write_arbiter_if bus ();

  reg_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.pipe_wr   = pw;
    bus.pipe_addr = pa;
    bus.pipe_data = pd;
    bus.lu_valid  = lv;
    bus.lu_addr   = la;
    bus.lu_data   = ld;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    wr_entry_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Samples the write port mid-cycle, then advances to the next falling edge.
  task automatic tick();
    wr_entry_t e;
    #2;
    if (bus.rf_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wr_addr", {27'd0, bus.rf_addr}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", {27'd0, bus.rf_addr}, {27'd0, e.addr});
        checkOutput("wr_data", bus.rf_data, e.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  next_lu;
    logic accepted;
    n_checks = 0;
    n_fail   = 0;

    reset = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd5, 32'h55);
    bus.lu_issue      = 1'b1;
    bus.lu_issue_addr = 5'd9;
    bus.rd_addr1      = 5'd0;
    bus.rd_addr2      = 5'd0;
    @(negedge clk);
    #1;
    checkOutput("rst_rf_wr", {31'd0, bus.rf_wr}, 32'd0);
    checkOutput("rst_rf_addr", {27'd0, bus.rf_addr}, 32'd0);
    checkOutput("rst_rf_data", bus.rf_data, 32'd0);
    checkOutput("rst_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
    checkOutput("rst_pending", bus.pending, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.lu_issue = 1'b0;
    #1;
    checkOutput("pre_edge_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
    tick();
    #1;
    checkOutput("post_rst_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
    checkOutput("post_rst_pending", bus.pending, 32'd0);

    // Scoreboard a long op to r8 and retire it.
    bus.lu_issue      = 1'b1;
    bus.lu_issue_addr = 5'd8;
    tick();
    bus.lu_issue = 1'b0;
    bus.rd_addr1 = 5'd8;
    #1;
    checkOutput("t35_pending8", {31'd0, bus.pending[8]}, 32'd1);
    checkOutput("t35_rd_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.rd_addr1 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h12345678);
    #1;
    checkOutput("t35_accept_no_wr", {31'd0, bus.rf_wr}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd8, 32'h12345678);
    #1;
    checkOutput("t35_pending8_at_wr", {31'd0, bus.pending[8]}, 32'd1);
    tick();
    #1;
    checkOutput("t35_pending8_cleared", {31'd0, bus.pending[8]}, 32'd0);
    checkOutput("t35_drain", exp_q.size(), 32'd0);

    // Register zero handling, read-after-write stall and write-after-write hold.
    bus.lu_issue      = 1'b1;
    bus.lu_issue_addr = 5'd7;
    tick();
    bus.lu_issue = 1'b0;
    bus.rd_addr1 = 5'd7;
    #1;
    checkOutput("t38_rd7_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.rd_addr1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("t38_zero_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t38_zero_no_wr", {31'd0, bus.rf_wr}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    #1;
    checkOutput("t38_lu0_ready", {31'd0, bus.lu_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("t38_lu0_no_wr", {31'd0, bus.rf_wr}, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("t38_waw_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("t38_waw_no_wr", {31'd0, bus.rf_wr}, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd7, 32'h77);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd7, 32'h77);
    #1;
    checkOutput("t38_waw_stall_pop", {31'd0, bus.stall}, 32'd1);
    tick();
    expectWrite(5'd7, 32'h70);
    #1;
    checkOutput("t38_waw_released", {31'd0, bus.stall}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("t38_drain", exp_q.size(), 32'd0);

    // Reissue to r10 in the same cycle its old result retires.
    bus.lu_issue      = 1'b1;
    bus.lu_issue_addr = 5'd10;
    tick();
    bus.lu_issue = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0A0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.lu_issue      = 1'b1;
    bus.lu_issue_addr = 5'd10;
    expectWrite(5'd10, 32'hA0A0);
    tick();
    bus.lu_issue = 1'b0;
    bus.rd_addr2 = 5'd10;
    #1;
    checkOutput("t39_pending10_kept", {31'd0, bus.pending[10]}, 32'd1);
    checkOutput("t39_rd2_stall", {31'd0, bus.stall}, 32'd1);
    bus.rd_addr2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hB0B0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd10, 32'hB0B0);
    tick();
    #1;
    checkOutput("t39_pending10_cleared", {31'd0, bus.pending[10]}, 32'd0);
    checkOutput("t39_drain", exp_q.size(), 32'd0);

    // Starvation: a buffered r9 result is forced out after four pipe wins.
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'h9999);
    expectWrite(5'd3, 32'hA);
    tick();
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) expectWrite(5'd9, 32'h9999);
      else        expectWrite(5'd3, 32'hA);
      #1;
      checkOutput($sformatf("t36_stall_%0d", i), {31'd0, bus.stall}, (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("t36_drain", exp_q.size(), 32'd0);

    // Back-to-back results overflow a two-entry buffer under constant pipe pressure.
    next_lu = 0;
    for (int c = 0; c < 17; c++) begin
      if (next_lu < 3)
        applyStimulus(1'b1, 5'd3, 32'hB, 1'b1, 5'(4 + next_lu), 32'h400 + 32'(4 + next_lu));
      else
        applyStimulus(1'b1, 5'd3, 32'hB, 1'b0, 5'd0, 32'h0);
      expectWrite(5'(exp_addr_37[c]),
                  (exp_addr_37[c] == 3) ? 32'hB : 32'h400 + 32'(exp_addr_37[c]));
      #1;
      checkOutput($sformatf("t37_ready_%0d", c), {31'd0, bus.lu_ready}, {31'd0, exp_rdy_37[c]});
      accepted = bus.lu_valid && bus.lu_ready;
      tick();
      if (accepted) next_lu++;
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("t37_all_accepted", next_lu, 32'd3);
    checkOutput("t37_drain", exp_q.size(), 32'd0);

    // Reset with a full buffer and r8/r9 pending.
    bus.lu_issue      = 1'b1;
    bus.lu_issue_addr = 5'd8;
    tick();
    bus.lu_issue_addr = 5'd9;
    tick();
    bus.lu_issue = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'hC, 1'b1, 5'd8, 32'h808);
    expectWrite(5'd3, 32'hC);
    tick();
    applyStimulus(1'b1, 5'd3, 32'hC, 1'b1, 5'd9, 32'h909);
    expectWrite(5'd3, 32'hC);
    tick();
    applyStimulus(1'b1, 5'd3, 32'hC, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("t40_pending_before", bus.pending, 32'h00000300);
    checkOutput("t40_full_before", {31'd0, bus.lu_ready}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("t40_rst_rf_wr", {31'd0, bus.rf_wr}, 32'd0);
    checkOutput("t40_rst_pending", bus.pending, 32'd0);
    checkOutput("t40_rst_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
    checkOutput("t40_rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    #1;
    checkOutput("t40_post_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
    checkOutput("t40_post_pending", bus.pending, 32'd0);
    checkOutput("t40_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
